// File: rtl/vga_value_display.sv
// 640x480@60 VGA block that draws the 5-bit input as two seven-segment decimal digits.
// Syncs and colour are registered one clk after the timing counters.
module vga_value_display #(
   parameter int H_VIS   = 640,
   parameter int H_FP    = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int V_VIS   = 480,
   parameter int V_FP    = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33,
   parameter int CLK_DIV = 4,
   parameter int TENS_X  = 256,
   parameter int UNITS_X = 336,
   parameter int BOX_Y   = 176
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] value,
   output logic       HSync,
   output logic       VSync,
   output logic [2:0] rgb
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);
   localparam int DIG_W = 64;
   localparam int DIG_H = 128;

   localparam logic [1:0]    PRESC_LAST = 2'(CLK_DIV - 1);
   localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
   localparam logic [HW-1:0] H_VIS_END  = HW'(H_VIS);
   localparam logic [VW-1:0] V_VIS_END  = VW'(V_VIS);
   localparam logic [HW-1:0] HS_BEG     = HW'(H_VIS + H_FP);
   localparam logic [HW-1:0] HS_END     = HW'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] VS_BEG     = VW'(V_VIS + V_FP);
   localparam logic [VW-1:0] VS_END     = VW'(V_VIS + V_FP + V_SYNC - 1);
   localparam logic [HW-1:0] TX_BEG     = HW'(TENS_X);
   localparam logic [HW-1:0] TX_END     = HW'(TENS_X + DIG_W - 1);
   localparam logic [HW-1:0] UX_BEG     = HW'(UNITS_X);
   localparam logic [HW-1:0] UX_END     = HW'(UNITS_X + DIG_W - 1);
   localparam logic [VW-1:0] BY_BEG     = VW'(BOX_Y);
   localparam logic [VW-1:0] BY_END     = VW'(BOX_Y + DIG_H - 1);

   logic [1:0]    presc;
   logic          pix_tick;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_last;
   logic          v_last;
   logic [4:0]    val_q;
   logic [3:0]    tens;
   logic [3:0]    units;
   logic [6:0]    pat_tens;
   logic [6:0]    pat_units;
   logic [5:0]    dx_tens;
   logic [5:0]    dx_units;
   logic [6:0]    dy;
   logic          in_row;
   logic          in_tens;
   logic          in_units;
   logic          visible;
   logic          lit;
   logic          hs_act;
   logic          vs_act;

   function automatic logic [6:0] seg_pattern(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'b1111110;
         4'd1:    p = 7'b0110000;
         4'd2:    p = 7'b1101101;
         4'd3:    p = 7'b1111001;
         4'd4:    p = 7'b0110011;
         4'd5:    p = 7'b1011011;
         4'd6:    p = 7'b1011111;
         4'd7:    p = 7'b1110000;
         4'd8:    p = 7'b1111111;
         4'd9:    p = 7'b1111011;
         default: p = 7'b0000000;
      endcase
      return p;
   endfunction

   // pat is {a,b,c,d,e,f,g}; dx/dy are local to a 64x128 digit box
   function automatic logic seg_hit(input logic [6:0] pat, input logic [5:0] dx,
                                    input logic [6:0] dy);
      logic mid_x;
      logic left_x;
      logic right_x;
      logic upper;
      logic lower;
      mid_x   = (dx >= 6'd8) && (dx <= 6'd55);
      left_x  = (dx <= 6'd7);
      right_x = (dx >= 6'd56);
      upper   = (dy >= 7'd8) && (dy <= 7'd63);
      lower   = (dy >= 7'd64) && (dy <= 7'd119);
      return (pat[6] & mid_x & (dy <= 7'd7))
           | (pat[5] & right_x & upper)
           | (pat[4] & right_x & lower)
           | (pat[3] & mid_x & (dy >= 7'd120))
           | (pat[2] & left_x & lower)
           | (pat[1] & left_x & upper)
           | (pat[0] & mid_x & (dy >= 7'd60) & (dy <= 7'd67));
   endfunction

   assign pix_tick = (presc == PRESC_LAST);
   assign h_last   = (h_cnt == H_LAST);
   assign v_last   = (v_cnt == V_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= 2'd0;
         h_cnt <= '0;
         v_cnt <= '0;
         val_q <= 5'd0;
      end else begin
         presc <= pix_tick ? 2'd0 : presc + 2'd1;
         if (pix_tick) begin
            if (h_last) begin
               h_cnt <= '0;
               v_cnt <= v_last ? '0 : v_cnt + VW'(1);
               // frame start: the displayed value only changes between frames
               if (v_last) val_q <= value;
            end else begin
               h_cnt <= h_cnt + HW'(1);
            end
         end
      end
   end

   always_comb begin
      if (val_q >= 5'd30) begin
         tens  = 4'd3;
         units = 4'(val_q - 5'd30);
      end else if (val_q >= 5'd20) begin
         tens  = 4'd2;
         units = 4'(val_q - 5'd20);
      end else if (val_q >= 5'd10) begin
         tens  = 4'd1;
         units = 4'(val_q - 5'd10);
      end else begin
         tens  = 4'd0;
         units = 4'(val_q);
      end
   end

   assign pat_tens  = seg_pattern(tens);
   assign pat_units = seg_pattern(units);
   assign dx_tens   = 6'(h_cnt - TX_BEG);
   assign dx_units  = 6'(h_cnt - UX_BEG);
   assign dy        = 7'(v_cnt - BY_BEG);
   assign in_row    = (v_cnt >= BY_BEG) && (v_cnt <= BY_END);
   assign in_tens   = (h_cnt >= TX_BEG) && (h_cnt <= TX_END);
   assign in_units  = (h_cnt >= UX_BEG) && (h_cnt <= UX_END);
   assign visible   = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
   assign hs_act    = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
   assign vs_act    = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
   assign lit       = in_row && ((in_tens && seg_hit(pat_tens, dx_tens, dy)) ||
                                 (in_units && seg_hit(pat_units, dx_units, dy)));

   always_ff @(posedge clk) begin
      if (rst) begin
         HSync <= 1'b1;
         VSync <= 1'b1;
         rgb   <= 3'b000;
      end else begin
         HSync <= ~hs_act;
         VSync <= ~vs_act;
         if (!visible)  rgb <= 3'b000;
         else if (lit)  rgb <= 3'b111;
         else           rgb <= 3'b001;
      end
   end

endmodule

// File: tb/tb_vga_value_display.sv
// Bench: full-size instance for line timing plus a shrunken-geometry instance so whole
// frames fit in a short run; both scored every clk against a reference model.
`timescale 1ns/1ps
module tb_vga_value_display;

   typedef struct {
      int hv, hf, hs, hb, vv, vf, vs, vb, div, tx, ux, by;
   } cfg_t;

   typedef struct {
      int         n;
      logic [4:0] ed;
      logic [4:0] es;
   } exp_t;

   localparam int S_HV = 146, S_HF = 2, S_HS = 4, S_HB = 2;
   localparam int S_VV = 130, S_VF = 1, S_VS = 2, S_VB = 1;
   localparam int S_DIV = 1, S_TX = 2, S_UX = 82, S_BY = 2;

   cfg_t cd = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 256, 336, 176};
   cfg_t cs = '{S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, S_DIV, S_TX, S_UX, S_BY};

   logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
   int rx0 [7] = '{8, 56, 56, 8, 0, 0, 8};
   int rx1 [7] = '{55, 63, 63, 55, 7, 7, 55};
   int ry0 [7] = '{0, 8, 64, 120, 64, 8, 60};
   int ry1 [7] = '{7, 63, 119, 127, 119, 63, 67};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] value = 5'd0;
   logic       hs_d, vs_d, hs_s, vs_s;
   logic [2:0] rgb_d, rgb_s;

   exp_t       q[$];
   exp_t       mon_e;
   int         n = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [4:0] fv_d [8];
   logic [4:0] fv_s [8];

   always #5 clk = ~clk;

   vga_value_display dut_d (
      .clk(clk), .rst(rst), .value(value), .HSync(hs_d), .VSync(vs_d), .rgb(rgb_d)
   );

   vga_value_display #(
      .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
      .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
      .CLK_DIV(S_DIV), .TENS_X(S_TX), .UNITS_X(S_UX), .BOX_Y(S_BY)
   ) dut_s (
      .clk(clk), .rst(rst), .value(value), .HSync(hs_s), .VSync(vs_s), .rgb(rgb_s)
   );

   function automatic int frame_pix(input cfg_t c);
      return (c.hv + c.hf + c.hs + c.hb) * (c.vv + c.vf + c.vs + c.vb);
   endfunction

   function automatic bit seg_on(input int d, input int dx, input int dy);
      for (int s = 0; s < 7; s++)
         if (seg_tab[d][6-s] && dx >= rx0[s] && dx <= rx1[s] && dy >= ry0[s] && dy <= ry1[s])
            return 1'b1;
      return 1'b0;
   endfunction

   // expected {HSync,VSync,rgb} seen after the edge that follows m clks since reset release
   function automatic logic [4:0] model(input cfg_t c, input int m, input logic [4:0] vq);
      int ht, vt, p, h, v, dy;
      logic hs, vs;
      logic [2:0] col;
      ht = c.hv + c.hf + c.hs + c.hb;
      vt = c.vv + c.vf + c.vs + c.vb;
      p  = m / c.div;
      h  = p % ht;
      v  = (p / ht) % vt;
      dy = v - c.by;
      hs = !(h >= c.hv + c.hf && h < c.hv + c.hf + c.hs);
      vs = !(v >= c.vv + c.vf && v < c.vv + c.vf + c.vs);
      if (h >= c.hv || v >= c.vv)
         col = 3'b000;
      else if (dy >= 0 && dy < 128 &&
               ((h >= c.tx && h < c.tx + 64 && seg_on(int'(vq) / 10, h - c.tx, dy)) ||
                (h >= c.ux && h < c.ux + 64 && seg_on(int'(vq) % 10, h - c.ux, dy))))
         col = 3'b111;
      else
         col = 3'b001;
      return {hs, vs, col};
   endfunction

   task automatic step(input bit r, input int force_val);
      exp_t e;
      int   fd, fs;
      @(negedge clk);
      rst = r;
      if (force_val >= 0) value = 5'(force_val);
      else if ($urandom_range(0, 63) == 0) value = 5'($urandom_range(0, 31));
      if (r) begin
         n = 0;
         for (int k = 0; k < 8; k++) begin
            fv_d[k] = 5'd0;
            fv_s[k] = 5'd0;
         end
         e.ed = 5'b11000;
         e.es = 5'b11000;
      end else begin
         n++;
         fd = frame_pix(cd) * cd.div;
         fs = frame_pix(cs) * cs.div;
         if (n % fd == 0 && n / fd < 8) fv_d[n / fd] = value;
         if (n % fs == 0 && n / fs < 8) fv_s[n / fs] = value;
         e.ed = model(cd, n - 1, fv_d[((n - 1) / fd) % 8]);
         e.es = model(cs, n - 1, fv_s[((n - 1) / fs) % 8]);
      end
      e.n = n;
      q.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            mon_e = q.pop_front();
            n_cmp++;
            if ({hs_d, vs_d, rgb_d} !== mon_e.ed) begin
               n_bad++;
               $display("FAIL full_out n=%0d got={hs,vs,rgb}=%b want=%b",
                        mon_e.n, {hs_d, vs_d, rgb_d}, mon_e.ed);
            end
            n_cmp++;
            if ({hs_s, vs_s, rgb_s} !== mon_e.es) begin
               n_bad++;
               $display("FAIL small_out n=%0d got={hs,vs,rgb}=%b want=%b",
                        mon_e.n, {hs_s, vs_s, rgb_s}, mon_e.es);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int fs;
      int fval;
      fs = frame_pix(cs) * cs.div;
      step(1'b1, 0);
      step(1'b1, 0);
      for (int i = 1; i <= 3400; i++) step(1'b0, -1);
      step(1'b1, -1);
      for (int i = 1; i <= 2 * fs + 132 * 154; i++) begin
         if (i == fs)                fval = 6;
         else if (i == fs + fs / 2)  fval = 7;
         else if (i == 2 * fs)       fval = 31;
         else                        fval = -1;
         step(1'b0, fval);
      end
      @(posedge clk);
      #2;
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL queue_drain got=%0d pending want=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
